// File: rtl/relay_motion_ctrl.sv
// Relay/H-bridge motion controller.
// Accepts direction/speed commands, ramps the bridge speed one step per RAMP_DIV clocks,
// brakes and inserts a bridge-off dead time on direction reversal, and handles overcurrent
// trips with a timed cool-down, bounded automatic restarts and a latched lockout.
module relay_motion_ctrl #(
    parameter int unsigned RAMP_DIV  = 100000,
    parameter int unsigned DEAD_CYC  = 50000,
    parameter int unsigned COOL_CYC  = 5000000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_dir,
    input  logic [3:0]  cmd_speed,
    input  logic [1:0]  OC,
    input  logic        fault_clr,
    output logic [3:0]  IN,
    output logic        en_allow,
    output logic [19:0] duty,
    output logic        busy,
    output logic        fault
);

    // Retry counter is sized so it can hold MAX_RETRY and still saturate safely.
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    localparam logic [22:0]   RampLast = 23'(RAMP_DIV - 1);
    localparam logic [22:0]   DeadLast = 23'(DEAD_CYC - 1);
    localparam logic [22:0]   CoolLast = 23'(COOL_CYC - 1);
    localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RetryOne = RW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StRamp,
        StRun,
        StBrake,
        StDead,
        StCool,
        StLock
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cur_dir_q, cur_dir_d;
    logic [1:0]    tgt_dir_q, tgt_dir_d;
    logic [3:0]    cur_spd_q, cur_spd_d;
    logic [3:0]    tgt_spd_q, tgt_spd_d;
    logic [22:0]   timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          oc_seen_q, oc_seen_d;

    logic          drive;
    logic          accept;
    logic          trip;
    logic          oc_any;
    logic [3:0]    dir_in;

    // Bridge-driving states, where overcurrent is monitored and the bridge may be enabled.
    always_comb begin
        drive  = (state_q == StRamp) || (state_q == StRun) || (state_q == StBrake);
        oc_any = |OC;
        accept = cmd_valid && cmd_ready;
        // A trip needs overcurrent on two consecutive driving clocks.
        trip      = drive && oc_any && oc_seen_q;
        oc_seen_d = drive && oc_any;
    end

    // Next-state and datapath update; a trip overrides everything decided before it.
    always_comb begin
        state_d   = state_q;
        cur_dir_d = cur_dir_q;
        tgt_dir_d = tgt_dir_q;
        cur_spd_d = cur_spd_q;
        tgt_spd_d = tgt_spd_q;
        retry_d   = retry_q;

        if (accept) begin
            tgt_dir_d = cmd_dir;
            tgt_spd_d = cmd_speed;
            retry_d   = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && (cmd_speed != 4'd0)) begin
                    cur_dir_d = cmd_dir;
                    state_d   = StRamp;
                end
            end
            StRun: begin
                if (accept) begin
                    state_d = (cmd_dir == cur_dir_q) ? StRamp : StBrake;
                end
            end
            StRamp: begin
                if (cur_spd_q == tgt_spd_q) begin
                    state_d = (cur_spd_q != 4'd0) ? StRun : StIdle;
                end else if (timer_q == RampLast) begin
                    // Target differs from current, so neither direction can wrap.
                    if (tgt_spd_q > cur_spd_q) begin
                        cur_spd_d = cur_spd_q + 4'd1;
                    end else begin
                        cur_spd_d = cur_spd_q - 4'd1;
                    end
                end
            end
            StBrake: begin
                if (cur_spd_q == 4'd0) begin
                    state_d = StDead;
                end else if (timer_q == RampLast) begin
                    cur_spd_d = cur_spd_q - 4'd1;
                end
            end
            StDead: begin
                if (timer_q == DeadLast) begin
                    cur_dir_d = tgt_dir_q;
                    state_d   = StRamp;
                end
            end
            StCool: begin
                if (timer_q == CoolLast) begin
                    if ((tgt_spd_q != 4'd0) && (retry_q < RetryMax)) begin
                        cur_dir_d = tgt_dir_q;
                        state_d   = StRamp;
                    end else if (tgt_spd_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StLock;
                    end
                end
            end
            StLock: begin
                if (fault_clr) begin
                    retry_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Trip wins over a same-cycle accept: targets stay loaded, retry clear is dropped.
        if (trip) begin
            cur_spd_d = '0;
            retry_d   = (retry_q == '1) ? retry_q : retry_q + RetryOne;
            state_d   = StCool;
        end
    end

    // Phase timer: restarts on every state entry, wraps at the ramp cadence in RAMP/BRAKE.
    always_comb begin
        timer_d = '0;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if ((state_q == StRamp) || (state_q == StBrake)) begin
            timer_d = (timer_q == RampLast) ? '0 : timer_q + 23'd1;
        end else if ((state_q == StDead) || (state_q == StCool)) begin
            timer_d = timer_q + 23'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_dir_q <= '0;
            tgt_dir_q <= '0;
            cur_spd_q <= '0;
            tgt_spd_q <= '0;
            timer_q   <= '0;
            retry_q   <= '0;
            oc_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_dir_q <= cur_dir_d;
            tgt_dir_q <= tgt_dir_d;
            cur_spd_q <= cur_spd_d;
            tgt_spd_q <= tgt_spd_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            oc_seen_q <= oc_seen_d;
        end
    end

    // Bridge input pattern for the current direction.
    always_comb begin
        dir_in = 4'b0000;
        unique case (cur_dir_q)
            2'b00: dir_in = 4'b0110;
            2'b01: dir_in = 4'b0101;
            2'b10: dir_in = 4'b1010;
            2'b11: dir_in = 4'b1001;
        endcase
    end

    // Outputs decode from registered state only, so reset forces them immediately.
    always_comb begin
        IN        = drive ? dir_in : 4'b0000;
        en_allow  = drive;
        cmd_ready = (state_q == StIdle) || (state_q == StRun);
        busy      = (state_q != StIdle) && (state_q != StLock);
        fault     = (state_q == StCool) || (state_q == StLock);
        // cur_spd * 65535 == (cur_spd << 16) - cur_spd, exact in 20 bits.
        duty      = {cur_spd_q, 16'h0000} - {16'h0000, cur_spd_q};
    end

endmodule

// File: doc/relay_motion_ctrl.md
RELAY_MOTION_CTRL -- requirements
Module: relay_motion_ctrl

Interface
REQ-001 Parameter RAMP_DIV, default 100000, clocks per one-step speed change.
REQ-002 Parameter DEAD_CYC, default 50000, clocks of bridge-off dead time on direction reversal.
REQ-003 Parameter COOL_CYC, default 5000000, clocks of cool-down after an overcurrent trip.
REQ-004 Parameter MAX_RETRY, default 3, number of automatic restarts before lockout.
REQ-005 Ports SHALL be, in order:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  motion command present.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_dir  in  2  00 fwd, 01 right, 10 left, 11 rev.
- cmd_speed  in  4  target speed 0..15; 0 means stop.
- OC  in  2  H-bridge overcurrent flags, either side.
- fault_clr  in  1  clears lockout (one-cycle pulse).
- IN  out  4  H-bridge inputs 1..4.
- en_allow  out  1  permits the PWM pulse onto the bridge enables.
- duty  out  20  PWM compare value.
- busy  out  1  high in any state except IDLE and LOCK.
- fault  out  1  high in COOL and LOCK.

Function
REQ-006 The FSM SHALL have states IDLE, RAMP, RUN, BRAKE, DEAD, COOL and LOCK, with registers cur_dir[1:0], tgt_dir[1:0], cur_spd[3:0], tgt_spd[3:0], a 23-bit timer and a retry counter.
REQ-007 cmd_ready SHALL be high only in IDLE and RUN.
REQ-008 On accept, tgt_dir and tgt_spd SHALL load and the retry counter SHALL clear.
REQ-009 On accept in IDLE with cmd_speed>0: cur_dir=cmd_dir, go to RAMP next cycle.
REQ-010 On accept in IDLE with cmd_speed=0: remain in IDLE.
REQ-011 On accept in RUN:
- same direction: go to RAMP.
- different direction: go to BRAKE.
REQ-012 RAMP SHALL step cur_spd by exactly ±1 toward tgt_spd each time the timer reaches RAMP_DIV-1, the timer resetting to 0.
REQ-013 RAMP exits when cur_spd==tgt_spd:
- to RUN if the value is nonzero.
- to IDLE if the value is 0.
REQ-014 BRAKE SHALL decrement cur_spd at the same RAMP_DIV cadence; at cur_spd==0 it goes to DEAD.
REQ-015 DEAD SHALL hold for DEAD_CYC clocks, then load cur_dir=tgt_dir and go to RAMP.
REQ-016 duty SHALL equal cur_spd*65535, computed in 20 bits without truncation; the maximum value is 983025.
REQ-017 IN SHALL map from cur_dir: 00->0110, 01->0101, 10->1010, 11->1001.
REQ-018 In RAMP, RUN and BRAKE, IN SHALL follow REQ-017 and en_allow SHALL be 1.
REQ-019 In IDLE, DEAD, COOL and LOCK, IN SHALL be 0000 and en_allow SHALL be 0.
REQ-020 OC filter: a trip occurs when any OC bit is high on 2 consecutive clocks in RAMP, RUN or BRAKE; OC SHALL be ignored in other states.
REQ-021 A trip SHALL, on the next edge:
- force cur_spd=0, increment the retry counter and enter COOL.
- take priority over a same-cycle command accept; the accepted tgt_dir/tgt_spd are retained but the retry clear is suppressed.
REQ-022 After COOL_CYC clocks, COOL SHALL exit:
- to RAMP (cur_dir=tgt_dir) if retry<MAX_RETRY and tgt_spd>0.
- to IDLE if tgt_spd==0.
- to LOCK otherwise.
REQ-023 LOCK SHALL be exited only by fault_clr, going to IDLE with the retry counter cleared; fault_clr in other states is ignored.
REQ-024 The timer SHALL clear on every state entry.
REQ-025 cur_spd SHALL never wrap below 0 or above 15.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=IDLE, all registers 0.
- IN=0000, en_allow=0, duty=0, cmd_ready=1, busy=0, fault=0.
- This applies in any state, including mid-ramp and mid-COOL.
REQ-027 The FSM SHALL leave IDLE no earlier than the first clock edge after rst_n deasserts.

Verification
Bench parameters: RAMP_DIV=2, DEAD_CYC=4, COOL_CYC=8, MAX_RETRY=2.
REQ-028 Ramp up: IDLE, accept fwd/speed 3 -> IN=0110, duty 65535, 131070, 196605 at 2-clock spacing, then RUN.
REQ-029 Reversal: RUN fwd/3, accept rev/2 -> duty ramps down to 0, then IN=0000 for 4 clocks, then IN=1001 and duty ramps to 131070.
REQ-030 Trip and retry: in RUN, OC=01 for 1 clock -> no effect; OC=01 for 2 clocks -> duty=0, fault=1 for 8 clocks, then re-ramp to target.
REQ-031 Lockout: two trips without a new command -> LOCK with fault=1 held; fault_clr pulse -> IDLE, fault=0.
REQ-032 Stop and reset: accept speed 0 in RUN -> ramps to IDLE with en_allow=0; asserting rst_n low mid-RAMP -> all outputs at reset values in the same cycle.
